// File: rtl/w_stage_regfile_pkg.sv
// Shared widths and select/extension codes for the writeback stage and register file.
package w_stage_regfile_pkg;

  localparam int WDSlen  = 3;
  localparam int TNewlen = 2;
  localparam int LDTlen  = 3;

  typedef enum logic [WDSlen-1:0] {
    WD_ALU = 3'd0,
    WD_MEM = 3'd1,
    WD_PC8 = 3'd2,
    WD_MDU = 3'd3,
    WD_CP0 = 3'd4
  } wdsel_e;

  typedef enum logic [LDTlen-1:0] {
    LD_NONE = 3'd0,
    LD_LW   = 3'd1,
    LD_LH   = 3'd2,
    LD_LHU  = 3'd3,
    LD_LB   = 3'd4,
    LD_LBU  = 3'd5
  } ldtype_e;

endpackage

// File: rtl/w_stage_regfile_load_ext.sv
// Sub-word load extender: picks the byte/half addressed by the low address bits
// and sign- or zero-extends it; word loads and unknown codes pass through.
module w_stage_regfile_load_ext
  import w_stage_regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_i,
  input  logic [1:0]        off_i,
  input  logic [LDTlen-1:0] ld_type_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_i[{off_i, 3'b000} +: 8];
  // Halfword alignment is trapped upstream, so only off_i[1] matters.
  assign half_sel = off_i[1] ? mem_i[31:16] : mem_i[15:0];

  always_comb begin
    data_o = mem_i;
    case (ldtype_e'(ld_type_i))
      LD_LB:   data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH:   data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: data_o = mem_i;
    endcase
  end

endmodule

// File: rtl/w_stage_regfile.sv
// MIPS writeback stage: source mux, register array with write-through bypass
// to the decode read ports, and the W-stage forwarding/commit outputs.
module w_stage_regfile
  import w_stage_regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               RFWrW,
  input  logic [WDSlen-1:0]  WDSelW,
  input  logic [ADDR_W-1:0]  DstW,
  input  logic [TNewlen-1:0] TNewW,
  input  logic [LDTlen-1:0]  LdTypeW,
  input  logic [DATA_W-1:0]  ALUW,
  input  logic [DATA_W-1:0]  MEMW,
  input  logic [DATA_W-1:0]  PC8W,
  input  logic [DATA_W-1:0]  MDUW,
  input  logic [DATA_W-1:0]  CP0W,
  input  logic [DATA_W-1:0]  PCW,
  input  logic [ADDR_W-1:0]  RA1D,
  input  logic [ADDR_W-1:0]  RA2D,
  output logic [DATA_W-1:0]  RD1D,
  output logic [DATA_W-1:0]  RD2D,
  output logic [DATA_W-1:0]  FwdDataW,
  output logic               FwdValidW,
  output logic               CommitW,
  output logic [DATA_W-1:0]  CommitPCW
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] mem_ext;
  logic [DATA_W-1:0] wb_data;
  logic              wr_en;

  w_stage_regfile_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .mem_i     (MEMW),
    .off_i     (ALUW[1:0]),
    .ld_type_i (LdTypeW),
    .data_o    (mem_ext)
  );

  always_comb begin
    wb_data = '0;
    case (wdsel_e'(WDSelW))
      WD_ALU:  wb_data = ALUW;
      WD_MEM:  wb_data = mem_ext;
      WD_PC8:  wb_data = PC8W;
      WD_MDU:  wb_data = MDUW;
      WD_CP0:  wb_data = CP0W;
      default: wb_data = '0;
    endcase
  end

  // Reset gates the write condition so nothing leaks through the bypass either.
  assign wr_en = reset && RFWrW && (DstW != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[DstW] <= wb_data;
    end
  end

  always_comb begin
    RD1D = '0;
    if (wr_en && (RA1D == DstW)) RD1D = wb_data;
    else if (reset && (RA1D != '0)) RD1D = regs_q[RA1D];
  end

  always_comb begin
    RD2D = '0;
    if (wr_en && (RA2D == DstW)) RD2D = wb_data;
    else if (reset && (RA2D != '0)) RD2D = regs_q[RA2D];
  end

  assign FwdDataW  = reset ? wb_data : '0;
  assign FwdValidW = wr_en && (TNewW == '0);
  assign CommitW   = FwdValidW;
  assign CommitPCW = reset ? PCW : '0;

endmodule
